// File: rtl/ppu_prog_loader.sv
// ppu_prog_loader
//   Fills the PPU instruction ROM and data RAM from a host byte stream and
//   keeps the PPU in reset until a complete, checksum-verified image is in.
//   Frame: 4-byte big-endian length N, N payload bytes, 1 checksum byte
//   (8-bit sum of the payload).
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   start          one-cycle pulse, restarts a load from RUN or ERR
//   in_valid/in_data/in_ready  host byte handshake (transfer on valid&&ready)
//   mem_we/mem_addr/mem_data   registered byte-write port to ROM and RAM
//   cpu_reset      PPU reset, high except in RUN
//   done           image loaded and verified
//   error          bad length or bad checksum
module ppu_prog_loader #(
  parameter int ADDR_W    = 9,
  parameter int MEM_BYTES = 512,
  parameter int RST_HOLD  = 2     // must be >= 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_CSUM, S_HOLD, S_RUN, S_ERR} state_t;

  state_t            state, state_n;
  // cnt is shared: length-byte index in LEN, payload index in DATA,
  // hold-cycle count in HOLD. Only one use is live per state.
  logic [31:0]       cnt, cnt_n;
  logic [31:0]       len, len_n, len_sh;
  logic [7:0]        csum, csum_n;
  logic              xfer, we_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        data_n;

  always_comb begin
    in_ready = !reset && (state == S_LEN || state == S_DATA || state == S_CSUM);
    xfer     = in_valid && in_ready;
    len_sh   = {len[23:0], in_data};
    state_n  = state;
    cnt_n    = cnt;
    len_n    = len;
    csum_n   = csum;
    we_n     = 1'b0;
    addr_n   = mem_addr;
    data_n   = mem_data;
    case (state)
      S_LEN: if (xfer) begin
        len_n = len_sh;
        if (cnt == 32'd3) begin
          cnt_n = '0;
          if (len_sh > 32'(MEM_BYTES)) state_n = S_ERR;
          else if (len_sh == 32'd0)    state_n = S_CSUM;
          else                         state_n = S_DATA;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_DATA: if (xfer) begin
        // length already bounded by MEM_BYTES, so the index fits ADDR_W
        we_n   = 1'b1;
        addr_n = cnt[ADDR_W-1:0];
        data_n = in_data;
        csum_n = csum + in_data;
        cnt_n  = cnt + 32'd1;
        if (cnt + 32'd1 == len) begin
          cnt_n   = '0;
          state_n = S_CSUM;
        end
      end
      S_CSUM: if (xfer) begin
        cnt_n   = '0;
        state_n = (in_data == csum) ? S_HOLD : S_ERR;
      end
      S_HOLD: begin
        if (cnt == 32'(RST_HOLD - 1)) begin
          cnt_n   = '0;
          state_n = S_RUN;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_RUN, S_ERR: if (start) begin
        state_n = S_LEN;
        cnt_n   = '0;
        len_n   = '0;
        csum_n  = '0;
      end
      default: state_n = S_LEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LEN;
      cnt       <= '0;
      len       <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      len       <= len_n;
      csum      <= csum_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_data  <= data_n;
      // status flags track the state being entered so they line up with it
      cpu_reset <= (state_n != S_RUN);
      done      <= (state_n == S_RUN);
      error     <= (state_n == S_ERR);
    end
  end

endmodule

// File: tb/tb_ppu_prog_loader.sv
// Bench for ppu_prog_loader: directed frames, a frame-grammar model that
// predicts every memory write, and literal checks of the status outputs.
module tb_ppu_prog_loader;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, mem_we, cpu_reset, done, error;
  logic [8:0] mem_addr;
  logic [7:0] mem_data;

  ppu_prog_loader #(.ADDR_W(9), .MEM_BYTES(512), .RST_HOLD(2)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_data(mem_data), .cpu_reset(cpu_reset),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         nchk   = 0;
  int         wr_cnt = 0;
  logic       chk_en = 1'b0;
  logic [7:0] mem_model [512];
  logic [7:0] pay [16];

  // frame model state
  int          p = 0;
  logic [31:0] mn = '0;
  logic        exp_we = 1'b0;
  logic [8:0]  exp_addr = '0;
  logic [7:0]  exp_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Model: byte position in the frame decides whether a write is due on the
  // next cycle (payload bytes of a legal-length frame only).
  always @(negedge clk) if (chk_en) begin
    chk("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
    if (exp_we && mem_we === 1'b1) begin
      chk("mem_addr", {23'd0, mem_addr}, {23'd0, exp_addr});
      chk("mem_data", {24'd0, mem_data}, {24'd0, exp_data});
      mem_model[mem_addr] = mem_data;
      wr_cnt++;
    end
    if (done === 1'b1) begin
      chk("run_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      chk("run_in_ready", {31'd0, in_ready}, 32'd0);
    end
    if (error === 1'b1) begin
      chk("err_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("err_done", {31'd0, done}, 32'd0);
    end
    if (reset) chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    exp_we = 1'b0;
    if (reset || start) begin
      p  = 0;
      mn = '0;
    end else if (in_valid && in_ready) begin
      if (p < 4) mn = {mn[23:0], in_data};
      else if (mn <= 32'd512 && 32'(p - 4) < mn) begin
        exp_we   = 1'b1;
        exp_addr = 9'(p - 4);
        exp_data = in_data;
      end
      p++;
    end
  end

  // entered and left at posedge+1
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input int n, input logic [7:0] cs, input int gap);
    logic [31:0] nn;
    nn = 32'(n);
    for (int i = 0; i < 4; i++) send_byte(nn[31-8*i -: 8]);
    for (int i = 0; i < n; i++) begin
      send_byte(pay[i]);
      idle(gap);
    end
    send_byte(cs);
  endtask

  // called right after the checksum byte: two HOLD cycles, then RUN
  task automatic hold_seq(input string tag);
    @(negedge clk);
    chk({tag, "_hold1_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    chk({tag, "_hold1_done"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    chk({tag, "_hold2_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
    @(negedge clk);
    chk({tag, "_run_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_run_cpu_reset"}, {31'd0, cpu_reset}, 32'd0);
    chk({tag, "_run_in_ready"}, {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    @(negedge clk);
    while (done !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_error"}, {31'd0, error}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem_model[i] = 8'h00;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // normal load
    pay[0] = 8'h82; pay[1] = 8'h10; pay[2] = 8'h20; pay[3] = 8'h05;
    wr_cnt = 0;
    send_frame(4, 8'hB7, 0);
    hold_seq("normal");
    chk("normal_writes", 32'(wr_cnt), 32'd4);
    chk("normal_m0", {24'd0, mem_model[0]}, 32'h82);
    chk("normal_m1", {24'd0, mem_model[1]}, 32'h10);
    chk("normal_m2", {24'd0, mem_model[2]}, 32'h20);
    chk("normal_m3", {24'd0, mem_model[3]}, 32'h05);

    // reload from RUN, then bad checksum
    start_pulse();
    @(negedge clk);
    chk("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("reload_done", {31'd0, done}, 32'd0);
    chk("reload_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send_frame(4, 8'hB6, 0);
    @(negedge clk);
    chk("badcs_error", {31'd0, error}, 32'd1);
    chk("badcs_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("badcs_done", {31'd0, done}, 32'd0);
    chk("badcs_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    start_pulse();
    @(negedge clk);
    chk("restart_error", {31'd0, error}, 32'd0);
    chk("restart_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send_frame(4, 8'hB7, 0);
    wait_done("badcs_retry");

    // oversize length 513
    start_pulse();
    wr_cnt = 0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h02); send_byte(8'h01);
    @(negedge clk);
    chk("oversize_error", {31'd0, error}, 32'd1);
    chk("oversize_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    idle(3);
    chk("oversize_writes", 32'(wr_cnt), 32'd0);
    start_pulse();

    // gapped stream
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    wr_cnt = 0;
    send_frame(4, 8'hAA, 3);
    wait_done("gapped");
    chk("gapped_writes", 32'(wr_cnt), 32'd4);
    chk("gapped_m0", {24'd0, mem_model[0]}, 32'h11);
    chk("gapped_m3", {24'd0, mem_model[3]}, 32'h44);

    // reset in the middle of the payload
    start_pulse();
    wr_cnt = 0;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'hA1); send_byte(8'hB2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    idle(4);
    chk("midrst_writes", 32'(wr_cnt), 32'd2);
    chk("midrst_m1", {24'd0, mem_model[1]}, 32'hB2);
    wr_cnt = 0;
    send_frame(0, 8'h00, 0);
    hold_seq("empty");
    chk("empty_writes", 32'(wr_cnt), 32'd0);

    // second image with checksum overflow overwrites low addresses only
    start_pulse();
    pay[0] = 8'h5A; pay[1] = 8'h6B; pay[2] = 8'h7C;
    wr_cnt = 0;
    send_frame(3, 8'h41, 0);
    hold_seq("reload2");
    chk("reload2_writes", 32'(wr_cnt), 32'd3);
    chk("reload2_m0", {24'd0, mem_model[0]}, 32'h5A);
    chk("reload2_m2", {24'd0, mem_model[2]}, 32'h7C);
    chk("reload2_m3", {24'd0, mem_model[3]}, 32'h44);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, nchk);
    $finish;
  end

endmodule

// File: doc/ppu_prog_loader.md
Name: ppu_prog_loader

Overview:
- Hardware program loader that fills PPU instruction ROM and data RAM from a byte stream. It replaces the bench-side load of the same image into both memories.
- Acts as the writer/initiator side of the memory-image path; the PPU fetch/load path is the reader.
- Holds the PPU in reset while loading. Releases it only after a verified image.
- Sits between a host byte source (UART/bench driver) and the PPU memory byte-write ports.

Parameters:
- ADDR_W, 9, byte-address width of memory write port.
- MEM_BYTES, 512, capacity in bytes; images longer than this are rejected.
- RST_HOLD, 2, cycles cpu_reset stays high after a successful load completes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; from RUN or ERR, restarts a load.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader accepts byte this cycle.
- mem_we  out  1  byte write strobe, driven to both ROM and RAM.
- mem_addr  out  ADDR_W  byte address.
- mem_data  out  8  byte to write.
- cpu_reset  out  1  reset to the PPU, active-high.
- done  out  1  image loaded and verified.
- error  out  1  load failed: bad length or bad checksum.

Behaviour:
- Reset (sync, highest priority):
  - state=LEN, byte counter=0, length=0, checksum=0.
  - mem_we=0, mem_addr=0, mem_data=0.
  - cpu_reset=1, done=0, error=0, in_ready=0 during reset cycle.
  - Reset mid-load abandons the partial image: no further writes, next load starts at LEN.
- Byte transfer: a byte transfers on a rising edge where in_valid && in_ready. in_valid may drop at any time; idle cycles cause no writes.
- in_ready = 1 in LEN, DATA, CSUM; 0 in HOLD, RUN, ERR.
- Frame format:
  - 4 length bytes, big-endian (SPARC order), value N in bytes.
  - N payload bytes.
  - 1 checksum byte = sum of payload bytes mod 256.
- States:
  - LEN: shift in 4 bytes. After the 4th byte: if N > MEM_BYTES -> ERR; if N == 0 -> CSUM; else -> DATA.
  - DATA: the k-th accepted payload byte (k=0..N-1) registers mem_we=1, mem_addr=k, mem_data=byte for exactly the next cycle; checksum accumulates. After the N-th byte -> CSUM.
  - CSUM: one byte accepted. If it equals the accumulated checksum -> HOLD; else -> ERR.
  - HOLD: counts RST_HOLD cycles with cpu_reset=1, then -> RUN.
  - RUN: cpu_reset=0, done=1. A start pulse -> LEN with cpu_reset=1, done=0, counters cleared.
  - ERR: error=1, cpu_reset=1, done=0. A start pulse -> LEN and clears error.
- mem_we is registered: one-cycle latency from transfer to write, never high for two cycles per byte, and 0 outside DATA writes.
- Address wrap cannot occur; the length check guarantees k < MEM_BYTES.
- start is ignored in LEN, DATA, CSUM, HOLD.
- Checksum arithmetic is 8-bit with silent overflow. The length register is 32 bits; comparison is unsigned.
- All outputs are registered except in_ready, which is decoded from state.

Test Plan:
- Normal load: bytes 00 00 00 04, 82 10 20 05, checksum B7 -> writes addr 0..3 = 82,10,20,05 on consecutive cycles; HOLD 2 cycles; then cpu_reset=0, done=1, in_ready=0.
- Bad checksum: same frame with checksum B6 -> error=1, cpu_reset stays 1, done=0; then start pulse plus the correct frame -> done=1, error=0.
- Oversize: length 00 00 02 01 (513) -> error=1 the cycle after the 4th byte, no mem_we ever, in_ready=0.
- Gapped stream: 4-byte payload with in_valid low for 3 cycles between each byte -> exactly 4 mem_we pulses, addresses 0..3, no duplicates.
- Reset mid-DATA: reset after 2 payload bytes -> no further writes, cpu_reset=1; a fresh frame 00 00 00 00, checksum 00 -> done=1 after RST_HOLD cycles, no writes.
- Reload from RUN: start pulse while done=1 -> cpu_reset=1 and done=0 next cycle, in_ready=1; a second image overwrites addr 0..N-1.
